// File: rtl/prio_enc_rr.sv
// Priority encoder with fixed or round-robin arbitration and a registered,
// ready/valid handshaked output index.
// Optional multi-hot capture counter: define PRIO_ENC_ERR_CNT_EN to enable
// err_cnt; otherwise err_cnt is tied to zero.
module prio_enc_rr #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] a,
   input  logic         mode,
   input  logic         y_ready,
   output logic [W-1:0] y,
   output logic         valid,
   output logic         multi,
   output logic [7:0]   err_cnt
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t       state_q, state_d;
   logic [W-1:0] y_q, ptr_q, ptr_d;
   logic         multi_q;

   logic         hs;        // consumer accepts the held index this cycle
   logic         cap;       // a new index is captured this cycle
   logic         any_req;
   logic         multi_d;
   logic [W-1:0] ptr_wrap;  // y_q + 1 modulo N
   logic [W-1:0] ptr_eff;   // pointer the round-robin scan starts from
   logic [W-1:0] fix_idx, rr_idx, sel_idx;
   logic         rr_hit;
   int           rr_j;

   assign any_req = |a;
   assign hs      = (state_q == HOLD) && y_ready;
   assign cap     = any_req && ((state_q == IDLE) || hs);
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_d = |(a & (a - N'(1)));

   assign ptr_wrap = (y_q == W'(N - 1)) ? '0 : y_q + W'(1);
   // A back-to-back capture must already see the pointer advanced by the
   // handshake happening in the same cycle.
   assign ptr_eff  = hs ? ptr_wrap : ptr_q;
   assign ptr_d    = hs ? ptr_wrap : ptr_q;

   // Fixed priority: last set bit in ascending scan is the highest index.
   always_comb begin
      fix_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (a[i]) fix_idx = W'(i);
      end
   end

   // Round-robin: first set bit scanning from ptr_eff upward with wrap at N.
   always_comb begin
      rr_idx = '0;
      rr_hit = 1'b0;
      rr_j   = 0;
      for (int k = 0; k < N; k++) begin
         rr_j = int'(ptr_eff) + k;
         if (rr_j >= N) rr_j = rr_j - N;
         if (!rr_hit && a[rr_j]) begin
            rr_hit = 1'b1;
            rr_idx = W'(rr_j);
         end
      end
   end

   assign sel_idx = mode ? rr_idx : fix_idx;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: hold until accepted, refill immediately if requests remain.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = HOLD;
         HOLD:    if (y_ready && !any_req) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from state.
   always_comb begin
      valid = (state_q == HOLD);
   end

   // Captured index, multi-hot flag and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q     <= '0;
         multi_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         ptr_q <= ptr_d;
         if (cap) begin
            y_q     <= sel_idx;
            multi_q <= multi_d;
         end
      end
   end

   assign y     = y_q;
   assign multi = multi_q;

`ifdef PRIO_ENC_ERR_CNT_EN
   logic [7:0] err_q;

   // Saturating count of multi-hot captures.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   err_q <= '0;
      else if (cap && multi_d && err_q != 8'hFF) err_q <= err_q + 8'd1;
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = 8'd0;
`endif

endmodule

// File: doc/prio_enc_rr.md
PRIO_ENC_RR -- requirements
Module: prio_enc_rr

Interface
REQ-001 Parameter N, default 8, number of request inputs; legal range 2..64, non-power-of-2 allowed.
REQ-002 Parameter W, default $clog2(N), index width; derived from N and not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 a  input  N  request vector; bit i = request i.
REQ-006 mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 y_ready  input  1  consumer accepts y this cycle.
REQ-008 y  output  W  registered index of the selected request.
REQ-009 valid  output  1  y holds a captured index awaiting acceptance.
REQ-010 multi  output  1  more than one bit of a was set at capture.
REQ-011 err_cnt  output  8  saturating multi-hot capture count (see Configuration).

Function
REQ-012 FSM states: IDLE (valid=0) and HOLD (valid=1).
REQ-013 IDLE with a!=0: capture y, multi; next state HOLD; valid rises the cycle after a is presented (1-cycle latency).
REQ-014 IDLE with a==0: stay IDLE; y, multi hold their previous values.
REQ-015 HOLD without y_ready: y, multi, valid stable; a and mode ignored.
REQ-016 HOLD with y_ready (handshake): if a!=0 same cycle, capture new y/multi and stay HOLD (back-to-back, no bubble); else go IDLE.
REQ-017 mode=0: y = highest index i with a[i]=1.
REQ-018 mode=1: y = first index i with a[i]=1 scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-019 ptr (W bits, internal) updates only on handshake: ptr = y+1, wrapping N-1 -> 0 (modulo N, also for non-power-of-2 N).
REQ-020 ptr updates on handshake in both modes; mode sampled only at capture.
REQ-021 multi = 1 when popcount(a) >= 2 at capture, else 0.
REQ-022 y_ready while IDLE has no effect.
REQ-023 Single-bit a: y equals that bit's index in both modes.

Reset
REQ-024 rst asserted: state=IDLE, y=0, valid=0, multi=0, ptr=0, err_cnt=0, immediately, independent of clk.
REQ-025 rst asserted during HOLD discards the pending index; no handshake is recorded.
REQ-026 First capture after rst release occurs on the first rising edge with rst low and a!=0.

Configuration
REQ-027 Macro PRIO_ENC_ERR_CNT_EN defined: err_cnt increments by 1 on every capture with multi=1, saturating at 255.
REQ-028 Macro PRIO_ENC_ERR_CNT_EN undefined: err_cnt tied to 0, no counter logic; all other behaviour identical.

Verification (N=8 unless noted)
REQ-029 rst pulse mid-HOLD (y=5, valid=1) -> y=0, valid=0, multi=0, err_cnt=0 immediately on rst assertion, before the next clk edge.
REQ-030 mode=0, a=8'b0010_0110, y_ready=1 -> one cycle later y=5, valid=1, multi=1; a=0 next -> valid=0 after handshake.
REQ-031 mode=1, a=8'hFF held, y_ready=1 -> y sequence 0,1,...,7,0 with valid continuously high.
REQ-032 mode=1, a=8'b1000_0001, y_ready=0 for 3 cycles -> y=0 stable, valid=1; then y_ready=1 -> next y=7, then 0.
REQ-033 N=5, mode=1, a=5'b10001, y_ready=1 -> y sequence 0,4,0,4 (ptr wraps 4 -> 0).
REQ-034 PRIO_ENC_ERR_CNT_EN defined, 300 multi-hot captures -> err_cnt=255; undefined -> err_cnt=0 throughout.
